fsm_chain: RTL and testbench



---
 rtl/fsm_chain_pkg.sv | 34 +++
 rtl/fsm_chain_ch.sv | 51 +++++
 rtl/fsm_chain.sv | 59 +++++
 tb/tb_fsm_chain.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_chain_pkg.sv
// Shared types and the per-channel transition rule for the coupled channel chain.
// Every channel instance evaluates the same rule, so it lives here in one place.
package fsm_chain_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } ch_state_t;

    // The last channel has no downstream neighbour, so it leaves DONE after a single cycle.
    function automatic ch_state_t ch_next_state(
        input ch_state_t state,
        input logic      en,
        input logic      cnt_zero,
        input logic      down_done,
        input logic      is_last
    );
        ch_state_t nxt;
        nxt = state;
        unique case (state)
            IDLE: nxt = en ? ARM : IDLE;
            ARM:  nxt = en ? RUN : IDLE;
            RUN:  nxt = cnt_zero ? DONE : RUN;
            DONE: nxt = (is_last || down_done) ? IDLE : DONE;
            default: nxt = IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/fsm_chain_ch.sv
// One channel of the chain: a 4-state register plus its RUN-length down counter.
// abort overrides every transition and clears the counter on the same edge.
module fsm_chain_ch
    import fsm_chain_pkg::*;
#(
    parameter int CNT_W   = 4,
    parameter int RUN_LEN = 5,
    parameter bit IS_LAST = 1'b0
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      en,
    input  logic      down_done,
    input  logic      abort,
    output ch_state_t state
);

    // RUN_LEN == 2**CNT_W loads all-ones, so the counter never needs an extra bit.
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(RUN_LEN - 1);

    ch_state_t        state_q;
    ch_state_t        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = ch_next_state(state_q, en, (cnt_q == '0), down_done, IS_LAST);
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if ((state_q == ARM) && en) begin
            cnt_d = LOAD_VAL;
        end else if ((state_q == RUN) && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    assign state = state_q;

endmodule

// File: rtl/fsm_chain.sv
// Chain of NUM_CH coupled channels; each channel is enabled by its upstream neighbour's DONE.
// All outputs decode registered state only, so in/abort have no combinational path out.
module fsm_chain
    import fsm_chain_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 4,
    parameter int RUN_LEN = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in,
    input  logic                  abort,
    output logic [2*NUM_CH-1:0]   state_o,
    output logic [NUM_CH-1:0]     busy_o,
    output logic                  done_o
);

    ch_state_t         ch_state [NUM_CH];
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] ch_down_done;

    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_ch
            if (k == 0) begin : g_head
                assign ch_en[k] = in;
            end else begin : g_link
                assign ch_en[k] = (ch_state[k-1] == DONE);
            end

            // A non-last channel holds DONE until its downstream neighbour has also reached DONE.
            if (k == NUM_CH - 1) begin : g_tail
                assign ch_down_done[k] = 1'b0;
            end else begin : g_mid
                assign ch_down_done[k] = (ch_state[k+1] == DONE);
            end

            fsm_chain_ch #(
                .CNT_W   (CNT_W),
                .RUN_LEN (RUN_LEN),
                .IS_LAST (k == NUM_CH - 1)
            ) u_ch (
                .clk       (clk),
                .reset     (reset),
                .en        (ch_en[k]),
                .down_done (ch_down_done[k]),
                .abort     (abort),
                .state     (ch_state[k])
            );

            assign state_o[2*k+1:2*k] = ch_state[k];
            assign busy_o[k]          = (ch_state[k] != IDLE);
        end
    endgenerate

    assign done_o = (ch_state[NUM_CH-1] == DONE);

endmodule

// File: tb/tb_fsm_chain.sv
// Scoreboarded random bench for fsm_chain: three configurations share one stimulus stream
// and are checked against a cycle-count reference model of the channel rules.
module tb_fsm_chain;

    localparam int S_IDLE = 0;
    localparam int S_ARM  = 1;
    localparam int S_RUN  = 2;
    localparam int S_DONE = 3;
    localparam int NCFG   = 3;
    localparam int CFG_CH  [NCFG] = '{4, 2, 2};
    localparam int CFG_LEN [NCFG] = '{5, 1, 16};

    logic clk      = 1'b0;
    logic reset    = 1'b0;
    logic inBit    = 1'b0;
    logic abortBit = 1'b0;

    logic [7:0] st0;
    logic [3:0] busy0;
    logic       done0;
    logic [3:0] st1;
    logic [1:0] busy1;
    logic       done1;
    logic [3:0] st2;
    logic [1:0] busy2;
    logic       done2;

    fsm_chain #(.NUM_CH(4), .CNT_W(4), .RUN_LEN(5)) dut0 (
        .clk(clk), .reset(reset), .in(inBit), .abort(abortBit),
        .state_o(st0), .busy_o(busy0), .done_o(done0)
    );
    fsm_chain #(.NUM_CH(2), .CNT_W(4), .RUN_LEN(1)) dut1 (
        .clk(clk), .reset(reset), .in(inBit), .abort(abortBit),
        .state_o(st1), .busy_o(busy1), .done_o(done1)
    );
    fsm_chain #(.NUM_CH(2), .CNT_W(4), .RUN_LEN(16)) dut2 (
        .clk(clk), .reset(reset), .in(inBit), .abort(abortBit),
        .state_o(st2), .busy_o(busy2), .done_o(done2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0][7:0] st;
        logic [2:0][3:0] busy;
        logic [2:0]      done;
    } exp_t;

    exp_t expQ[$];
    int   mst [NCFG][4];
    int   mel [NCFG][4];
    int   firstDone [NCFG];
    int   errors  = 0;
    int   checks  = 0;
    bit   started = 1'b0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: mel counts cycles already spent in RUN, up to the configured length.
    function automatic void modelStep(input bit inV, input bit abortV, input bit resetV);
        int nst [NCFG][4];
        int nel [NCFG][4];
        bit en;
        bit last;
        bit down;
        for (int c = 0; c < NCFG; c++) begin
            for (int k = 0; k < 4; k++) begin
                nst[c][k] = S_IDLE;
                nel[c][k] = 0;
            end
        end
        if (!(resetV || abortV)) begin
            for (int c = 0; c < NCFG; c++) begin
                for (int k = 0; k < CFG_CH[c]; k++) begin
                    if (k == 0) en = inV;
                    else        en = (mst[c][k-1] == S_DONE);
                    last = (k == CFG_CH[c] - 1);
                    down = 1'b0;
                    if (!last) down = (mst[c][k+1] == S_DONE);
                    case (mst[c][k])
                        S_IDLE: nst[c][k] = en ? S_ARM : S_IDLE;
                        S_ARM: begin
                            if (en) begin
                                nst[c][k] = S_RUN;
                                nel[c][k] = 1;
                            end
                        end
                        S_RUN: begin
                            if (mel[c][k] >= CFG_LEN[c]) begin
                                nst[c][k] = S_DONE;
                            end else begin
                                nst[c][k] = S_RUN;
                                nel[c][k] = mel[c][k] + 1;
                            end
                        end
                        S_DONE: nst[c][k] = (last || down) ? S_IDLE : S_DONE;
                        default: nst[c][k] = S_IDLE;
                    endcase
                end
            end
        end
        mst = nst;
        mel = nel;
    endfunction

    function automatic exp_t modelExpect();
        exp_t e;
        e = '0;
        for (int c = 0; c < NCFG; c++) begin
            for (int k = 0; k < CFG_CH[c]; k++) begin
                e.st[c][2*k +: 2] = 2'(mst[c][k]);
                e.busy[c][k]      = (mst[c][k] != S_IDLE);
            end
            e.done[c] = (mst[c][CFG_CH[c]-1] == S_DONE);
        end
        return e;
    endfunction

    task automatic applyStimulus(input bit inV, input bit abortV);
        inBit    = inV;
        abortBit = abortV;
        modelStep(inV, abortV, reset);
        expQ.push_back(modelExpect());
        started = 1'b1;
        @(negedge clk);
    endtask

    task automatic runMeasure(input int n);
        for (int c = 0; c < NCFG; c++) firstDone[c] = -1;
        for (int i = 1; i <= n; i++) begin
            applyStimulus(1'b1, 1'b0);
            if (done0 === 1'b1 && firstDone[0] < 0) firstDone[0] = i;
            if (done1 === 1'b1 && firstDone[1] < 0) firstDone[1] = i;
            if (done2 === 1'b1 && firstDone[2] < 0) firstDone[2] = i;
        end
    endtask

    // Reset lands mid-cycle; outputs must clear before the next clock edge.
    task automatic resetMidCycle();
        #2 reset = 1'b1;
        #1;
        checkOutput("async_rst_state0", int'(st0), 0);
        checkOutput("async_rst_busy0", int'(busy0), 0);
        checkOutput("async_rst_state1", int'(st1), 0);
        checkOutput("async_rst_state2", int'(st2), 0);
        applyStimulus(1'b0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() == 0) begin
                if (started) checkOutput("scoreboard_empty", 0, 1);
            end else begin
                e = expQ.pop_front();
                checkOutput("cfg0_state", int'(st0), int'(e.st[0]));
                checkOutput("cfg0_busy", int'(busy0), int'(e.busy[0]));
                checkOutput("cfg0_done", int'(done0), int'(e.done[0]));
                checkOutput("cfg1_state", int'(st1), int'(e.st[1]));
                checkOutput("cfg1_busy", int'(busy1), int'(e.busy[1]));
                checkOutput("cfg1_done", int'(done1), int'(e.done[1]));
                checkOutput("cfg2_state", int'(st2), int'(e.st[2]));
                checkOutput("cfg2_busy", int'(busy2), int'(e.busy[2]));
                checkOutput("cfg2_done", int'(done2), int'(e.done[2]));
            end
        end
    end

    initial begin : stimulus
        int  waited;
        bit  sawDone;
        for (int c = 0; c < NCFG; c++) begin
            for (int k = 0; k < 4; k++) begin
                mst[c][k] = S_IDLE;
                mel[c][k] = 0;
            end
        end

        #1 reset = 1'b1;
        #1;
        checkOutput("reset_state0", int'(st0), 0);
        checkOutput("reset_busy0", int'(busy0), 0);
        checkOutput("reset_done0", int'(done0), 0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        reset = 1'b0;

        // in held high from idle: first done_o lands at (NUM_CH)*(RUN_LEN+2) edges.
        runMeasure(45);
        checkOutput("first_done_cfg0", firstDone[0], 28);
        checkOutput("first_done_cfg1", firstDone[1], 6);
        checkOutput("first_done_cfg2", firstDone[2], 36);
        repeat (60) applyStimulus(1'b1, 1'b0);

        // Abort while channel 1 of the default chain is in RUN, then restart.
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        repeat (9) applyStimulus(1'b1, 1'b0);
        checkOutput("pre_abort_ch1_run", int'(st0[3:2]), S_RUN);
        applyStimulus(1'b1, 1'b1);
        checkOutput("abort_state0", int'(st0), 0);
        checkOutput("abort_busy0", int'(busy0), 0);
        runMeasure(45);
        checkOutput("restart_done_cfg0", firstDone[0], 28);
        checkOutput("restart_done_cfg1", firstDone[1], 6);
        checkOutput("restart_done_cfg2", firstDone[2], 36);

        // A one-cycle enable arms channel 0 and falls straight back to IDLE.
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("pulse_busy0", int'(busy0), 1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("pulse_idle_busy0", int'(busy0), 0);
        sawDone = 1'b0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b0);
            if (done0 !== 1'b0) sawDone = 1'b1;
        end
        checkOutput("pulse_no_done", int'(sawDone), 0);

        // Drive until channel 2 of the default chain is in RUN, then reset asynchronously.
        waited = 0;
        while (mst[0][2] != S_RUN && waited < 60) begin
            applyStimulus(1'b1, 1'b0);
            waited++;
        end
        checkOutput("wait_ch2_run", int'(waited < 60), 1);
        resetMidCycle();
        repeat (3) applyStimulus(1'b0, 1'b0);
        runMeasure(40);
        checkOutput("post_reset_done_cfg0", firstDone[0], 28);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                resetMidCycle();
            end else begin
                applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 23) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
